// File: rtl/digit_seq_ctrl.sv
// Sequenced digit source: steps an index through a six-entry digit table,
// manually or self-timed, with a handshaked table/length write port.
module digit_seq_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic       rev,
    input  logic       auto_en,
    input  logic [7:0] tick_div,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic       wr_ack,
    output logic [3:0] digit,
    output logic [2:0] idx,
    output logic       wrap
);

    typedef enum logic [1:0] {
        MAN   = 2'd0,
        AUTO  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] len_q, len_d;
    logic [3:0] tbl_q [0:5];
    logic [3:0] tbl_d [0:5];
    logic [7:0] presc_q, presc_d, presc_next_s;
    logic       pend_q, pend_d;
    logic       pend_rev_q, pend_rev_d;
    logic       step_prev_q;
    logic       wr_lock_q, wr_lock_d;
    logic [2:0] waddr_q, waddr_d;
    logic [3:0] wdata_q, wdata_d;
    logic       wr_ack_q, wr_ack_d;
    logic       wrap_q, wrap_d;
    logic       step_rise_s, accept_s, step_dir_s;
    logic [2:0] new_len_s;
    logic [3:0] nxt_s;

    // Stored length is always within 1..6.
    function automatic logic [2:0] clamp_len(input logic [2:0] v);
        case (v)
            3'd0:    clamp_len = 3'd1;
            3'd7:    clamp_len = 3'd6;
            default: clamp_len = v;
        endcase
    endfunction

    // Returns {wrap, next index} for one step in the given direction.
    function automatic logic [3:0] next_pos(input logic [2:0] cur, input logic [2:0] len,
                                            input logic dir);
        if (dir) begin
            if (cur == 3'd0) next_pos = {1'b1, len - 3'd1};
            else             next_pos = {1'b0, cur - 3'd1};
        end else begin
            if (cur == len - 3'd1) next_pos = {1'b1, 3'd0};
            else                   next_pos = {1'b0, cur + 3'd1};
        end
    endfunction

    assign step_rise_s = step & ~step_prev_q;
    assign accept_s    = wr_en & ~wr_lock_q & (state_q != WRITE);
    // A manual step uses the direction captured when its edge was seen.
    assign step_dir_s  = (state_q == MAN) ? pend_rev_q : rev;
    assign nxt_s       = next_pos(idx_q, len_q, step_dir_s);
    assign new_len_s   = clamp_len(wdata_q[2:0]);

    // Next-state logic for the sequencer, prescaler and write handshake.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        tbl_d        = tbl_q;
        presc_d      = 8'd0;
        presc_next_s = 8'd0;
        pend_d       = pend_q;
        pend_rev_d   = pend_rev_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        wr_lock_d    = wr_lock_q;
        wr_ack_d     = 1'b0;
        wrap_d       = 1'b0;

        case (state_q)
            MAN: begin
                if (pend_q) {wrap_d, idx_d} = nxt_s;
                else        {wrap_d, idx_d} = {1'b0, idx_q};
                pend_d = step_rise_s;
                if (step_rise_s) pend_rev_d = rev;
                else             pend_rev_d = pend_rev_q;
                if (accept_s)     state_d = WRITE;
                else if (auto_en) state_d = AUTO;
                else              state_d = MAN;
            end
            AUTO: begin
                pend_d = 1'b0;
                if (presc_q == tick_div) begin
                    {wrap_d, idx_d} = nxt_s;
                    presc_next_s    = 8'd0;
                end else begin
                    {wrap_d, idx_d} = {1'b0, idx_q};
                    presc_next_s    = presc_q + 8'd1;
                end
                if (accept_s)      state_d = WRITE;
                else if (!auto_en) state_d = MAN;
                else               state_d = AUTO;
                presc_d = (state_d == AUTO) ? presc_next_s : 8'd0;
            end
            WRITE: begin
                pend_d = pend_q | step_rise_s;
                if (step_rise_s) pend_rev_d = rev;
                else             pend_rev_d = pend_rev_q;
                if (waddr_q < 3'd6) begin
                    tbl_d[waddr_q] = wdata_q;
                end else if (waddr_q == 3'd6) begin
                    len_d = new_len_s;
                    // Shrinking below the current position snaps back silently.
                    if (idx_q >= new_len_s) idx_d = 3'd0;
                    else                    idx_d = idx_q;
                end else begin
                    len_d = len_q;
                end
                state_d = auto_en ? AUTO : MAN;
            end
            default: begin
                state_d = MAN;
                pend_d  = 1'b0;
            end
        endcase

        if (accept_s) begin
            wr_lock_d = 1'b1;
            waddr_d   = wr_addr;
            wdata_d   = wr_data;
            wr_ack_d  = 1'b1;
        end else if (!wr_en) begin
            wr_lock_d = 1'b0;
        end else begin
            wr_lock_d = wr_lock_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= MAN;
            idx_q       <= 3'd0;
            len_q       <= 3'd6;
            for (int i = 0; i < 6; i++) tbl_q[i] <= 4'(i);
            presc_q     <= 8'd0;
            pend_q      <= 1'b0;
            pend_rev_q  <= 1'b0;
            step_prev_q <= 1'b0;
            wr_lock_q   <= 1'b0;
            waddr_q     <= 3'd0;
            wdata_q     <= 4'd0;
            wr_ack_q    <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            tbl_q       <= tbl_d;
            presc_q     <= presc_d;
            pend_q      <= pend_d;
            pend_rev_q  <= pend_rev_d;
            step_prev_q <= step;
            wr_lock_q   <= wr_lock_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            wr_ack_q    <= wr_ack_d;
            wrap_q      <= wrap_d;
        end
    end

    assign wr_ack = wr_ack_q;
    assign wrap   = wrap_q;
    assign idx    = idx_q;
    assign digit  = (idx_q < 3'd6) ? tbl_q[idx_q] : 4'd0;

endmodule

// File: tb/tb_digit_seq_ctrl.sv
// Directed bench for digit_seq_ctrl: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences.
module tb_digit_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       step;
    logic       rev;
    logic       auto_en;
    logic [7:0] tick_div;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_ack;
    logic [3:0] digit;
    logic [2:0] idx;
    logic       wrap;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       stp;
        logic       rv;
        logic       we;
        logic [2:0] wa;
        logic [3:0] wd;
        logic [2:0] e_idx;
        logic [3:0] e_dig;
        logic       e_wrap;
        logic       e_ack;
    } vec_t;

    vec_t vecs[$];

    digit_seq_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .step    (step),
        .rev     (rev),
        .auto_en (auto_en),
        .tick_div(tick_div),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_ack  (wr_ack),
        .digit   (digit),
        .idx     (idx),
        .wrap    (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic r, input logic we, input logic [2:0] wa,
                       input logic [3:0] wd, input logic [2:0] ei, input logic [3:0] ed,
                       input logic ew, input logic ea);
        vecs.push_back('{s, r, we, wa, wd, ei, ed, ew, ea});
    endtask

    task automatic do_step(input logic r);
        step = 1'b1;
        rev  = r;
        tick();
        step = 1'b0;
        tick();
    endtask

    task automatic do_write(input logic [2:0] a, input logic [3:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        chk("write accept ack", 32'(wr_ack), 32'd1);
        wr_en = 1'b0;
        tick();
        chk("write commit ack", 32'(wr_ack), 32'd0);
    endtask

    initial begin
        int exp_i;
        int acks;
        int wraps;
        logic exp_w;

        reset = 1'b1; step = 1'b0; rev = 1'b0; auto_en = 1'b0;
        tick_div = 8'd0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 4'd0;
        #2 reset = 1'b0;
        #1;
        chk("reset idx", 32'(idx), 32'd0);
        chk("reset digit", 32'(digit), 32'd0);
        chk("reset wrap", 32'(wrap), 32'd0);
        chk("reset ack", 32'(wr_ack), 32'd0);
        tick();
        tick();
        reset = 1'b1;

        // Six forward steps: each is a step edge then a service edge.
        for (int k = 1; k <= 6; k++) begin
            add(1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 3'(k - 1), 4'(k - 1), 1'b0, 1'b0);
            add(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 3'(k % 6), 4'(k % 6), (k == 6), 1'b0);
        end
        // Reverse from 0 wraps to 5; direction captured at the step edge.
        add(1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 3'd5, 4'd5, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 3'd5, 4'd5, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 3'd5, 4'd5, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 3'd0, 4'd0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 3'd5, 4'd5, 1'b1, 1'b0);
        // Held write to table[2]: exactly one ack.
        add(1'b0, 1'b0, 1'b1, 3'd2, 4'd9, 3'd5, 4'd5, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b1, 3'd2, 4'd9, 3'd5, 4'd5, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 3'd2, 4'd9, 3'd5, 4'd5, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 3'd2, 4'd9, 3'd5, 4'd5, 1'b0, 1'b0);
        // Step round to idx 2 and see the written value.
        add(1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 3'd5, 4'd5, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 3'd0, 4'd0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 3'd1, 4'd1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 3'd1, 4'd1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 3'd2, 4'd9, 1'b0, 1'b0);
        // No-op address still acks; then rewrite the displayed entry.
        add(1'b0, 1'b0, 1'b1, 3'd7, 4'd15, 3'd2, 4'd9, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 3'd7, 4'd15, 3'd2, 4'd9, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 3'd2, 4'd4, 3'd2, 4'd9, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 3'd2, 4'd4, 3'd2, 4'd4, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            step    = vecs[i].stp;
            rev     = vecs[i].rv;
            wr_en   = vecs[i].we;
            wr_addr = vecs[i].wa;
            wr_data = vecs[i].wd;
            tick();
            chk($sformatf("vec%0d idx", i), 32'(idx), 32'(vecs[i].e_idx));
            chk($sformatf("vec%0d digit", i), 32'(digit), 32'(vecs[i].e_dig));
            chk($sformatf("vec%0d wrap", i), 32'(wrap), 32'(vecs[i].e_wrap));
            chk($sformatf("vec%0d ack", i), 32'(wr_ack), 32'(vecs[i].e_ack));
        end
        step = 1'b0; rev = 1'b0; wr_en = 1'b0;

        // Length write to 3 while at idx 4, wr_en held five cycles.
        do_step(1'b0);
        do_step(1'b0);
        chk("pre-len idx", 32'(idx), 32'd4);
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 4'd3;
        acks = 0; wraps = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            acks  = acks + int'(wr_ack);
            wraps = wraps + int'(wrap);
        end
        wr_en = 1'b0;
        tick();
        chk("len write ack count", 32'(acks), 32'd1);
        chk("len write wrap count", 32'(wraps), 32'd0);
        chk("len write idx", 32'(idx), 32'd0);
        do_step(1'b0);
        chk("len3 step1 idx", 32'(idx), 32'd1);
        do_step(1'b0);
        chk("len3 step2 digit", 32'(digit), 32'd4);
        do_step(1'b0);
        chk("len3 wrap idx", 32'(idx), 32'd0);
        chk("len3 wrap pulse", 32'(wrap), 32'd1);

        // Step edge in the accepting cycle: write first, step afterwards.
        step = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'd8;
        tick();
        chk("step+write ack", 32'(wr_ack), 32'd1);
        chk("step+write idx0", 32'(idx), 32'd0);
        step = 1'b0; wr_en = 1'b0;
        tick();
        chk("step+write commit idx", 32'(idx), 32'd0);
        chk("step+write commit digit", 32'(digit), 32'd8);
        tick();
        chk("step+write late step idx", 32'(idx), 32'd1);
        chk("step+write late step digit", 32'(digit), 32'd1);

        // Self-timed stepping, period 4 (len 3, starting at idx 1).
        tick_div = 8'd3; auto_en = 1'b1; exp_i = 1;
        for (int e = 1; e <= 15; e++) begin
            tick();
            exp_w = 1'b0;
            if (e > 1 && (e - 1) % 4 == 0) begin
                exp_w = (exp_i == 2);
                exp_i = (exp_i + 1) % 3;
            end
            chk($sformatf("auto e%0d idx", e), 32'(idx), 32'(exp_i));
            chk($sformatf("auto e%0d wrap", e), 32'(wrap), 32'(exp_w));
        end
        auto_en = 1'b0;
        for (int e = 0; e < 6; e++) begin
            tick();
            chk($sformatf("auto off e%0d idx", e), 32'(idx), 32'd1);
        end
        // Re-entry restarts the prescaler; step edges are ignored in AUTO.
        auto_en = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            if (e == 2) step = 1'b1;
            if (e == 3) step = 1'b0;
            tick();
            chk($sformatf("reentry e%0d idx", e), 32'(idx), (e == 5) ? 32'd2 : 32'd1);
        end
        tick_div = 8'd0; exp_i = 2;
        for (int e = 1; e <= 5; e++) begin
            if (e == 5) auto_en = 1'b0;
            tick();
            exp_w = (exp_i == 2);
            exp_i = (exp_i + 1) % 3;
            chk($sformatf("div0 e%0d idx", e), 32'(idx), 32'(exp_i));
            chk($sformatf("div0 e%0d wrap", e), 32'(wrap), 32'(exp_w));
        end
        for (int e = 0; e < 3; e++) begin
            tick();
            chk($sformatf("man hold e%0d idx", e), 32'(idx), 32'(exp_i));
        end

        // Length clamping: 0 stores 1, 7 stores 6.
        do_write(3'd6, 4'd0);
        chk("len0 idx", 32'(idx), 32'd0);
        chk("len0 no wrap", 32'(wrap), 32'd0);
        do_step(1'b0);
        chk("len1 fwd idx", 32'(idx), 32'd0);
        chk("len1 fwd wrap", 32'(wrap), 32'd1);
        do_step(1'b1);
        chk("len1 rev idx", 32'(idx), 32'd0);
        chk("len1 rev wrap", 32'(wrap), 32'd1);
        do_write(3'd6, 4'd7);
        do_step(1'b1);
        chk("len7 clamp idx", 32'(idx), 32'd5);
        chk("len7 clamp wrap", 32'(wrap), 32'd1);

        // Reset during WRITE aborts it; a held wr_en is accepted afterwards.
        rev = 1'b0; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'd9;
        tick();
        chk("pre-reset ack", 32'(wr_ack), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("mid-write reset ack", 32'(wr_ack), 32'd0);
        chk("mid-write reset idx", 32'(idx), 32'd0);
        chk("mid-write reset digit", 32'(digit), 32'd0);
        chk("mid-write reset wrap", 32'(wrap), 32'd0);
        wr_addr = 3'd1; wr_data = 4'd12;
        tick();
        chk("held reset ack", 32'(wr_ack), 32'd0);
        reset = 1'b1;
        tick();
        chk("post-reset accept ack", 32'(wr_ack), 32'd1);
        tick();
        chk("post-reset commit ack", 32'(wr_ack), 32'd0);
        wr_en = 1'b0;
        chk("post-reset table0", 32'(digit), 32'd0);
        do_step(1'b0);
        chk("post-reset table1", 32'(digit), 32'd12);
        do_step(1'b0);
        chk("post-reset table2", 32'(digit), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/digit_seq_ctrl.md
DIGIT_SEQ_CTRL -- requirements
Module: digit_seq_ctrl

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `reset`: input, 1 bit, asynchronous, active-low; 0 forces the reset state immediately.
REQ-003 The block SHALL have the port `step`: input, 1 bit, manual step request; acted on at its rising edge only.
REQ-004 The block SHALL have the port `rev`: input, 1 bit, direction select; 0 = forward, 1 = reverse.
REQ-005 The block SHALL have the port `auto_en`: input, 1 bit; 1 = self-timed stepping, 0 = manual stepping.
REQ-006 The block SHALL have the port `tick_div`: input, 8 bits, auto-step period minus one, in clocks.
REQ-007 The block SHALL have the port `wr_en`: input, 1 bit, table write request; held high until `wr_ack`.
REQ-008 The block SHALL have the port `wr_addr`: input, 3 bits; 0-5 = table entry, 6 = sequence length, 7 = no-op.
REQ-009 The block SHALL have the port `wr_data`: input, 4 bits, write payload.
REQ-010 The block SHALL have the port `wr_ack`: output, 1 bit, one-cycle pulse when a write commits.
REQ-011 The block SHALL have the port `digit`: output, 4 bits; equals table[idx] and feeds the 7-segment converter.
REQ-012 The block SHALL have the port `idx`: output, 3 bits, current sequence position.
REQ-013 The block SHALL have the port `wrap`: output, 1 bit, one-cycle pulse on any wrap-around step.

Function
REQ-014 The state machine SHALL have exactly the states MAN, AUTO and WRITE.
REQ-015 MAN SHALL go to AUTO when `auto_en`=1, and AUTO SHALL go to MAN when `auto_en`=0; each transition completes on the next edge.
REQ-016 From MAN or AUTO, an accepted write request SHALL enter WRITE, and WRITE SHALL take exactly one cycle, then go to AUTO if `auto_en`=1 else MAN.
REQ-017 A write request SHALL be accepted only if `wr_en`=1 and `wr_en` was 0 at some edge since the previous ack, so a held request commits exactly once.
REQ-018 In WRITE, `wr_ack`=1 and the write SHALL commit as follows:
- addr 0-5: table[addr] := `wr_data`.
- addr 6: len := `wr_data`[2:0], with 0 stored as 1 and values above 6 stored as 6.
- addr 7: no change, but `wr_ack` is still pulsed.
REQ-019 If a length write makes idx >= new len, idx SHALL become 0 on the same edge, with no `wrap` pulse.
REQ-020 A rising edge of `step` SHALL be detected against the registered previous value and SHALL set a pending-step flag.
REQ-021 A pending step SHALL be serviced, and cleared, on the first edge in MAN that is not a WRITE cycle.
REQ-022 In AUTO, `step` edges SHALL be ignored and the pending flag SHALL be cleared.
REQ-023 In AUTO, an 8-bit prescaler SHALL count 0..`tick_div`; at count==`tick_div` the block SHALL take one step and the count returns to 0.
REQ-024 `tick_div`=0 SHALL produce one step per clock.
REQ-025 The prescaler SHALL be held at 0 outside AUTO and SHALL restart from 0 on every entry to AUTO.
REQ-026 A forward step SHALL set idx := idx+1, except when idx = len-1, in which case idx := 0 and `wrap` pulses.
REQ-027 A reverse step SHALL set idx := idx-1, except when idx = 0, in which case idx := len-1 and `wrap` pulses.
REQ-028 With len=1, every step SHALL leave idx at 0 and pulse `wrap`.
REQ-029 `rev` SHALL be sampled on the step edge, so a direction change applies to the next step with no extra latency.
REQ-030 `digit` SHALL be combinational from the registered idx and table, so it changes in the same cycle as idx, including after a write to table[idx].
REQ-031 `wrap` and `wr_ack` SHALL be registered single-cycle pulses.

Reset
REQ-032 While `reset`=0, the state SHALL be MAN, with idx=0, len=6 and table = {0,1,2,3,4,5}.
REQ-033 While `reset`=0, the prescaler, the pending flag and the step/wr_en history SHALL all be 0.
REQ-034 While `reset`=0, `wr_ack`=0, `wrap`=0 and `digit`=0.
REQ-035 A reset asserted mid-WRITE SHALL abort the write with no table change and no ack.
REQ-036 After `reset` releases, a `wr_en` still held high SHALL be accepted, because its history was cleared to 0.

Verification
REQ-037 Scenario: reset, then 6 `step` edges with `rev`=0 -> digit 1,2,3,4,5,0; `wrap` pulses only on the 6th step.
REQ-038 Scenario: `rev`=1 from reset, 1 step -> idx=5, digit=5, `wrap`=1 for one cycle.
REQ-039 Scenario: `auto_en`=1 with `tick_div`=3 -> steps every 4 clocks; drop `auto_en` -> no further steps, prescaler=0.
REQ-040 Scenario: with idx=4, write addr 6 data 3 -> len=3, idx=0, `wr_ack` one pulse with `wr_en` held 5 cycles.
REQ-041 Scenario: `step` edge in the same cycle a write is accepted -> write commits first, step taken on the next edge.
REQ-042 Scenario: write addr 2 data 9, step to idx 2 -> digit=9; assert `reset` mid-sequence -> idx=0 and table[2]=2 immediately.
